decoder: RTL and testbench
==========================

DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rdy  input  1  global ready; low = pause, all registers hold.
REQ-005 rollback_signal  input  1  pipeline flush; synchronous, active-high.
REQ-006 in_valid  input  1  instr holds a fetched instruction this cycle.
REQ-007 instr  input  32  RV32I instruction word.
REQ-008 out_valid  output  1  registered outputs hold a decoded instruction.
REQ-009 is_ls  output  1  load or store (goes to LSB).
REQ-010 is_jump  output  1  conditional branch (B-type).
REQ-011 optype  output  6  operation code (REQ-013).
REQ-012 rd, rs1, rs2  output  5 each  register indices; imm  output  32  decoded immediate.

Function
REQ-013 optype encoding: 0 NOP/illegal; 1 LUI; 2 AUIPC; 3 JAL; 4 JALR; 5-10 BEQ, BNE, BLT, BGE, BLTU, BGEU; 11-15 LB, LH, LW, LBU, LHU; 16-18 SB, SH, SW; 19-27 ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; 28-37 ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
REQ-014 Selection: opcode instr[6:0], funct3 instr[14:12], funct7 instr[31:25].
- instr[30] splits ADD/SUB, SRL/SRA and SRLI/SRAI.
- Any unlisted opcode/funct combination decodes as optype 0.
REQ-015 Latency is exactly 1 cycle: outputs sampled at edge N appear after edge N and hold until the next accepted update.
REQ-016 Each edge with rst=0, rollback_signal=0, rdy=1:
- out_valid <= in_valid.
- All other outputs <= decode(instr), regardless of in_valid.
REQ-017 rdy=0 (with rst=0 and rollback_signal=0): every output holds its value.
REQ-018 rollback_signal=1: out_valid <= 0, all other outputs <= 0; this overrides rdy=0.
REQ-019 rd = instr[11:7] for R, I, load, JALR, LUI, AUIPC, JAL; 0 for B, S and illegal.
REQ-020 rs1 = instr[19:15] for R, I, load, S, B, JALR; 0 for LUI, AUIPC, JAL and illegal.
REQ-021 rs2 = instr[24:20] for R, S, B; 0 otherwise.
REQ-022 imm, all sign-extended from instr[31] unless stated:
- I/load/JALR: instr[31:20].
- SLLI/SRLI/SRAI: instr[24:20], zero-extended.
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- R and illegal: 0.
REQ-023 is_ls = 1 exactly for optype 11-18; is_jump = 1 exactly for optype 5-10; both 0 for illegal.
REQ-024 Illegal instruction with in_valid=1: out_valid=1, optype=0, all other outputs 0.
REQ-025 Decode is purely a function of instr; no state is carried across instructions.

Reset
REQ-026 rst=1 at an edge: all outputs <= 0; rst takes priority over rollback_signal and rdy.
REQ-027 An instruction in flight when rst or rollback_signal asserts is discarded, never emitted.

Verification
REQ-028 instr 0x00500093 (addi x1,x0,5), in_valid=1 -> next cycle: out_valid=1, optype=19, rd=1, rs1=0, rs2=0, imm=5, is_ls=0, is_jump=0.
REQ-029 instr 0xFE208EE3 (beq x1,x2,-4) -> optype=5, is_jump=1, rd=0, rs1=1, rs2=2, imm=0xFFFFFFFC.
REQ-030 instr 0x00112423 (sw x1,8(x2)) -> optype=18, is_ls=1, rs1=2, rs2=1, rd=0, imm=8; then 0x4020D193 (srai x3,x1,2) -> optype=27, imm=2.
REQ-031 instr 0x123452B7 (lui x5) -> optype=1, rd=5, rs1=0, imm=0x12345000; then 0x008000EF (jal x1,8) -> optype=3, rd=1, imm=8.
REQ-032 Valid decode present, rdy=0 for 3 cycles while instr changes -> outputs unchanged; rollback_signal=1 with rdy=0 -> out_valid=0 next cycle.
REQ-033 in_valid=1, instr=0xFFFFFFFF -> out_valid=1, optype=0, all other outputs 0; rst=1 mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/decoder_if.sv
// ----------------------------------------------------------------------------
// decoder_if -- fetch-to-decode bus and decoded-instruction result bus.
//
// Handshake: in_valid qualifies instr for one cycle; there is no back-pressure
// on this bus because the global rdy/rollback_signal/rst inputs of the decoder
// control when a word is taken. out_valid qualifies the registered decode
// fields. The fields are updated on every accepted edge even when out_valid is
// low, so consumers must look at them only while out_valid is high.
//
// Signals:
//   in_valid  fetch -> decoder  instr holds a fetched instruction this cycle
//   instr     fetch -> decoder  RV32I instruction word
//   out_valid decoder -> user   decode fields hold a decoded instruction
//   is_ls     decoder -> user   load or store
//   is_jump   decoder -> user   conditional branch (B-type)
//   optype    decoder -> user   operation code (0 = NOP/illegal)
//   rd/rs1/rs2 decoder -> user  register indices
//   imm       decoder -> user   decoded immediate
// ----------------------------------------------------------------------------
interface decoder_if;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_valid;
    logic        is_ls;
    logic        is_jump;
    logic [5:0]  optype;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;

    // Fetch side drives the instruction and observes the decode result.
    modport master (
        output in_valid, instr,
        input  out_valid, is_ls, is_jump, optype, rd, rs1, rs2, imm
    );

    // Decoder side takes the instruction and drives the decode result.
    modport slave (
        input  in_valid, instr,
        output out_valid, is_ls, is_jump, optype, rd, rs1, rs2, imm
    );
endinterface

// File: rtl/decoder.sv
// ----------------------------------------------------------------------------
// decoder -- single-cycle RV32I instruction decoder with registered outputs.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset, highest priority
//   rdy              global ready; low holds every output register
//   rollback_signal  synchronous flush; clears outputs even when rdy is low
//   bus              decoder_if.slave (in_valid/instr in, decode fields out)
//
// Combinational decode of instr feeds a bank of output registers. Decode is a
// pure function of the current word; nothing is carried between instructions.
// ----------------------------------------------------------------------------
module decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       rollback_signal,
    decoder_if.slave   bus
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_LB    = 6'd11;
    localparam logic [5:0] OP_LHU   = 6'd15;
    localparam logic [5:0] OP_SB    = 6'd16;
    localparam logic [5:0] OP_SW    = 6'd18;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_ANDI  = 6'd24;
    localparam logic [5:0] OP_SLLI  = 6'd25;
    localparam logic [5:0] OP_SRAI  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd28;
    localparam logic [5:0] OP_AND   = 6'd37;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign instr  = bus.instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    logic [5:0]  optype_d, optype_q;
    logic [4:0]  rd_d, rd_q;
    logic [4:0]  rs1_d, rs1_q;
    logic [4:0]  rs2_d, rs2_q;
    logic [31:0] imm_d, imm_q;
    logic        is_ls_d, is_ls_q;
    logic        is_jump_d, is_jump_q;
    logic        out_valid_q;

    // Operation code. Every unmatched opcode/funct combination stays OP_NOP.
    always_comb begin
        optype_d = OP_NOP;
        case (opcode)
            OPC_LUI:   optype_d = OP_LUI;
            OPC_AUIPC: optype_d = OP_AUIPC;
            OPC_JAL:   optype_d = OP_JAL;
            OPC_JALR:  if (funct3 == 3'b000) optype_d = OP_JALR;
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  optype_d = 6'd5;
                    3'b001:  optype_d = 6'd6;
                    3'b100:  optype_d = 6'd7;
                    3'b101:  optype_d = 6'd8;
                    3'b110:  optype_d = 6'd9;
                    3'b111:  optype_d = 6'd10;
                    default: optype_d = OP_NOP;
                endcase
            end
            OPC_LOAD: begin
                case (funct3)
                    3'b000:  optype_d = 6'd11;
                    3'b001:  optype_d = 6'd12;
                    3'b010:  optype_d = 6'd13;
                    3'b100:  optype_d = 6'd14;
                    3'b101:  optype_d = 6'd15;
                    default: optype_d = OP_NOP;
                endcase
            end
            OPC_STORE: begin
                case (funct3)
                    3'b000:  optype_d = 6'd16;
                    3'b001:  optype_d = 6'd17;
                    3'b010:  optype_d = 6'd18;
                    default: optype_d = OP_NOP;
                endcase
            end
            OPC_OPIMM: begin
                case (funct3)
                    3'b000: optype_d = 6'd19;
                    3'b010: optype_d = 6'd20;
                    3'b011: optype_d = 6'd21;
                    3'b100: optype_d = 6'd22;
                    3'b110: optype_d = 6'd23;
                    3'b111: optype_d = 6'd24;
                    // Shift-immediates reuse the upper immediate bits as funct7.
                    3'b001: if (funct7 == F7_BASE) optype_d = 6'd25;
                    3'b101: begin
                        if (funct7 == F7_BASE)     optype_d = 6'd26;
                        else if (funct7 == F7_ALT) optype_d = 6'd27;
                    end
                    default: optype_d = OP_NOP;
                endcase
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  optype_d = 6'd28;
                        3'b001:  optype_d = 6'd30;
                        3'b010:  optype_d = 6'd31;
                        3'b011:  optype_d = 6'd32;
                        3'b100:  optype_d = 6'd33;
                        3'b101:  optype_d = 6'd34;
                        3'b110:  optype_d = 6'd36;
                        default: optype_d = 6'd37;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    // Only SUB and SRA have the alternate funct7.
                    if (funct3 == 3'b000)      optype_d = 6'd29;
                    else if (funct3 == 3'b101) optype_d = 6'd35;
                end
            end
            default: optype_d = OP_NOP;
        endcase
    end

    // Operand fields and immediate, selected by instruction class. Working from
    // the decoded optype (rather than the raw opcode) makes illegal words fall
    // out as all-zero without separate checks.
    always_comb begin
        logic is_b, is_s, is_r, is_ld, is_i, is_sh;
        is_b  = (optype_d >= OP_BEQ)  && (optype_d <= OP_BGEU);
        is_s  = (optype_d >= OP_SB)   && (optype_d <= OP_SW);
        is_r  = (optype_d >= OP_ADD)  && (optype_d <= OP_AND);
        is_ld = (optype_d >= OP_LB)   && (optype_d <= OP_LHU);
        is_i  = (optype_d >= OP_ADDI) && (optype_d <= OP_ANDI);
        is_sh = (optype_d >= OP_SLLI) && (optype_d <= OP_SRAI);

        is_ls_d   = is_ld || is_s;
        is_jump_d = is_b;

        rd_d  = '0;
        rs1_d = '0;
        rs2_d = '0;
        imm_d = '0;

        if ((optype_d != OP_NOP) && !is_b && !is_s) rd_d = instr[11:7];
        // JALR and every class numbered above it read rs1.
        if (optype_d >= OP_JALR) rs1_d = instr[19:15];
        if (is_b || is_s || is_r) rs2_d = instr[24:20];

        if (optype_d == OP_LUI || optype_d == OP_AUIPC) begin
            imm_d = {instr[31:12], 12'b0};
        end else if (optype_d == OP_JAL) begin
            imm_d = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        end else if (is_b) begin
            imm_d = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        end else if (is_s) begin
            imm_d = {{21{instr[31]}}, instr[30:25], instr[11:7]};
        end else if (is_sh) begin
            imm_d = {27'b0, instr[24:20]};
        end else if (is_i || is_ld || optype_d == OP_JALR) begin
            imm_d = {{21{instr[31]}}, instr[30:20]};
        end
    end

    // Output registers. rst beats rollback_signal beats rdy; a flush clears the
    // stage even while the pipeline is paused so a squashed word never leaks.
    always_ff @(posedge clk) begin
        if (rst || rollback_signal) begin
            out_valid_q <= 1'b0;
            optype_q    <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            is_ls_q     <= 1'b0;
            is_jump_q   <= 1'b0;
        end else if (rdy) begin
            out_valid_q <= bus.in_valid;
            optype_q    <= optype_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            is_ls_q     <= is_ls_d;
            is_jump_q   <= is_jump_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.optype    = optype_q;
    assign bus.rd        = rd_q;
    assign bus.rs1       = rs1_q;
    assign bus.rs2       = rs2_q;
    assign bus.imm       = imm_q;
    assign bus.is_ls     = is_ls_q;
    assign bus.is_jump   = is_jump_q;

endmodule

// File: tb/tb_decoder.sv
// ----------------------------------------------------------------------------
// tb_decoder -- directed-vector bench for decoder. The driver applies one
// vector per clock and pushes the hand-computed register contents expected
// after that edge; the monitor pops one entry after each edge and compares.
// ----------------------------------------------------------------------------
module tb_decoder;

    logic clk;
    logic rst;
    logic rdy;
    logic rollback_signal;

    decoder_if dif ();

    decoder dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .rollback_signal (rollback_signal),
        .bus             (dif.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Packed layout: {out_valid, is_ls, is_jump, optype, rd, rs1, rs2, imm}
    localparam int W = 56;
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks;
    int           errors;
    logic [W-1:0] last_exp;

    function automatic logic [W-1:0] pk(input logic ov, input logic ls,
                                        input logic jp, input logic [5:0] op,
                                        input logic [4:0] rd, input logic [4:0] r1,
                                        input logic [4:0] r2, input logic [31:0] imm);
        return {ov, ls, jp, op, rd, r1, r2, imm};
    endfunction

    // ---------------- driver ----------------
    // Inputs change just after the falling edge so they are stable at the next
    // rising edge; exp is what the registers must hold after that edge.
    task automatic drive(input string nm, input logic r, input logic rb,
                         input logic rd_y, input logic iv, input logic [31:0] ins,
                         input logic [W-1:0] exp);
        @(negedge clk);
        #1;
        rst             = r;
        rollback_signal = rb;
        rdy             = rd_y;
        dif.in_valid    = iv;
        dif.instr       = ins;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        last_exp = exp;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        string        nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {dif.out_valid, dif.is_ls, dif.is_jump, dif.optype,
                       dif.rd, dif.rs1, dif.rs2, dif.imm};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL %s: got ov=%b ls=%b j=%b op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h, want ov=%b ls=%b j=%b op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h",
                             nm, act[55], act[54], act[53], act[52:47], act[46:42],
                             act[41:37], act[36:32], act[31:0], exp[55], exp[54],
                             exp[53], exp[52:47], exp[46:42], exp[41:37], exp[36:32],
                             exp[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] zero;
    logic [W-1:0] addi_exp;

    initial begin
        int wait_cycles;
        checks          = 0;
        errors          = 0;
        zero            = '0;
        rst             = 1'b1;
        rdy             = 1'b0;
        rollback_signal = 1'b0;
        dif.in_valid    = 1'b0;
        dif.instr       = '0;

        addi_exp = pk(1, 0, 0, 6'd19, 5'd1, 5'd0, 5'd0, 32'd5);

        // Reset state, also with an instruction and rollback asserted.
        drive("reset",        1, 1, 1, 1, 32'h00500093, zero);
        drive("reset_rdy0",   1, 0, 0, 1, 32'h00500093, zero);

        // Main decode vectors.
        drive("addi",   0, 0, 1, 1, 32'h00500093, addi_exp);
        drive("beq",    0, 0, 1, 1, 32'hFE208EE3, pk(1, 0, 1, 6'd5,  5'd0, 5'd1, 5'd2, 32'hFFFFFFFC));
        drive("sw",     0, 0, 1, 1, 32'h00112423, pk(1, 1, 0, 6'd18, 5'd0, 5'd2, 5'd1, 32'd8));
        drive("srai",   0, 0, 1, 1, 32'h4020D193, pk(1, 0, 0, 6'd27, 5'd3, 5'd1, 5'd0, 32'd2));
        drive("lui",    0, 0, 1, 1, 32'h123452B7, pk(1, 0, 0, 6'd1,  5'd5, 5'd0, 5'd0, 32'h12345000));
        drive("jal",    0, 0, 1, 1, 32'h008000EF, pk(1, 0, 0, 6'd3,  5'd1, 5'd0, 5'd0, 32'd8));
        drive("lw_neg", 0, 0, 1, 1, 32'hFFC12283, pk(1, 1, 0, 6'd13, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC));
        drive("jalr",   0, 0, 1, 1, 32'h010280E7, pk(1, 0, 0, 6'd4,  5'd1, 5'd5, 5'd0, 32'd16));
        drive("auipc",  0, 0, 1, 1, 32'h80000397, pk(1, 0, 0, 6'd2,  5'd7, 5'd0, 5'd0, 32'h80000000));
        drive("sltu",   0, 0, 1, 1, 32'h0062B233, pk(1, 0, 0, 6'd32, 5'd4, 5'd5, 5'd6, 32'd0));
        drive("sub",    0, 0, 1, 1, 32'h402081B3, pk(1, 0, 0, 6'd29, 5'd3, 5'd1, 5'd2, 32'd0));
        drive("bad_f7", 0, 0, 1, 1, 32'h40001033, pk(1, 0, 0, 6'd0,  5'd0, 5'd0, 5'd0, 32'd0));
        // Fields still decode with in_valid low; only out_valid drops.
        drive("add_iv0", 0, 0, 1, 0, 32'h002081B3, pk(0, 0, 0, 6'd28, 5'd3, 5'd1, 5'd2, 32'd0));

        // Stall: outputs hold while instr changes, then flush while stalled.
        drive("addi2",   0, 0, 1, 1, 32'h00500093, addi_exp);
        drive("hold1",   0, 0, 0, 1, 32'hFE208EE3, addi_exp);
        drive("hold2",   0, 0, 0, 0, 32'h00112423, addi_exp);
        drive("hold3",   0, 0, 0, 1, 32'hFFFFFFFF, addi_exp);
        drive("rb_rdy0", 0, 1, 0, 1, 32'h00500093, zero);
        drive("rb_rdy1", 0, 1, 1, 1, 32'h123452B7, zero);

        // All-ones word is illegal but still valid.
        drive("illegal", 0, 0, 1, 1, 32'hFFFFFFFF, pk(1, 0, 0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0));
        // Reset mid-stream discards the in-flight word.
        drive("pre_rst", 0, 0, 1, 1, 32'h008000EF, pk(1, 0, 0, 6'd3, 5'd1, 5'd0, 5'd0, 32'd8));
        drive("mid_rst", 1, 0, 1, 1, 32'h00500093, zero);
        drive("post_rst", 0, 0, 1, 1, 32'h00500093, addi_exp);

        // Park inputs idle and let the monitor drain the queue.
        @(negedge clk);
        #1;
        rdy          = 1'b0;
        dif.in_valid = 1'b0;
        wait_cycles  = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
